// File: rtl/intc_pkg.sv
// intc_pkg: shared FSM encoding and default vector constants for the interrupt controller
package intc_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, SVC = 2'd2} intc_state_t;
   localparam logic [31:0] VEC_BASE_DEF   = 32'h0000_0080;
   localparam logic [31:0] VEC_STRIDE_DEF = 32'h0000_0008;
   localparam logic [31:0] NMI_VEC_DEF    = 32'h0000_0040;
   function automatic int id_width(input int n);
      return n > 1 ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/intc_prio_enc.sv
// intc_prio_enc: combinational lowest-index priority encoder
module intc_prio_enc #(
   parameter int N   = 4,
   parameter int IDW = 2
) (
   input  logic [N-1:0]   req,
   output logic           valid,
   output logic [IDW-1:0] id
);
   assign valid = |req;
   always_comb begin
      id = '0;
      for (int i = N - 1; i >= 0; i--) if (req[i]) id = IDW'(i);
   end
endmodule

// File: rtl/interrupt_controller.sv
// interrupt_controller: latches IRQ/NMI edges, arbitrates them and hands one request at a time
// to the CPU controller at instruction boundaries, with single-level NMI preemption.
module interrupt_controller
   import intc_pkg::*;
#(
   parameter int          NUM_IRQ    = 4,
   parameter logic [31:0] VEC_BASE   = VEC_BASE_DEF,
   parameter logic [31:0] VEC_STRIDE = VEC_STRIDE_DEF,
   parameter logic [31:0] NMI_VEC    = NMI_VEC_DEF,
   localparam int         IDW        = id_width(NUM_IRQ)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_IRQ-1:0] irq,
   input  logic               nmi,
   input  logic [NUM_IRQ-1:0] int_mask,
   input  logic               intd,
   input  logic               boundary,
   input  logic               int_ack,
   input  logic               eret,
   output logic               int_req,
   output logic               is_nmi,
   output logic [IDW-1:0]     irq_id,
   output logic [31:0]        vector,
   output logic               in_service,
   output logic [NUM_IRQ-1:0] pending
);
   intc_state_t state, state_n;
   logic [NUM_IRQ-1:0] irq_q, clr;
   logic nmi_q, nmi_pend, nest_int, svc_nmi;
   logic [IDW-1:0] save_id, enc_id;
   logic enc_valid, nmi_cand, mask_cand, take, ack, withdraw, preempt, ret;

   function automatic logic [31:0] vec_of(input logic n, input logic [IDW-1:0] id);
      return n ? NMI_VEC : VEC_BASE + 32'(id) * VEC_STRIDE;
   endfunction

   intc_prio_enc #(.N(NUM_IRQ), .IDW(IDW)) u_enc (
      .req  (pending & int_mask & {NUM_IRQ{~intd}}),
      .valid(enc_valid),
      .id   (enc_id)
   );

   assign in_service = state == SVC || nest_int;
   assign int_req    = state == REQ;
   assign nmi_cand   = nmi_pend && !svc_nmi;
   assign mask_cand  = enc_valid && !in_service;
   assign ack        = int_req && int_ack;
   // A maskable request is pulled back if its enable drops before the controller accepts it
   assign withdraw   = int_req && !int_ack && !is_nmi && !(int_mask[irq_id] && !intd);
   assign take       = state == IDLE && boundary && (nmi_cand || mask_cand);
   assign preempt    = state == SVC && !svc_nmi && boundary && nmi_cand;
   assign ret        = state == SVC && eret;
   assign clr        = ack && !is_nmi ? NUM_IRQ'(1) << irq_id : '0;

   always_comb begin
      state_n = take || preempt ? REQ : ack ? SVC : withdraw || (ret && !nest_int) ? IDLE : state;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         irq_q    <= '0;
         nmi_q    <= 1'b0;
         pending  <= '0;
         nmi_pend <= 1'b0;
         is_nmi   <= 1'b0;
         irq_id   <= '0;
         vector   <= '0;
         nest_int <= 1'b0;
         svc_nmi  <= 1'b0;
         save_id  <= '0;
      end else begin
         irq_q    <= irq;
         nmi_q    <= nmi;
         pending  <= (pending & ~clr) | (irq & ~irq_q);
         nmi_pend <= (nmi_pend && !(ack && is_nmi)) || (nmi && !nmi_q);
         if (take || preempt) begin
            is_nmi <= nmi_cand;
            irq_id <= nmi_cand ? '0 : enc_id;
            vector <= vec_of(nmi_cand, enc_id);
         end
         if (preempt) begin
            nest_int <= 1'b1;
            save_id  <= irq_id;
         end
         if (ack) svc_nmi <= is_nmi;
         if (ret) begin
            svc_nmi <= 1'b0;
            if (nest_int) begin
               nest_int <= 1'b0;
               is_nmi   <= 1'b0;
               irq_id   <= save_id;
               vector   <= vec_of(1'b0, save_id);
            end
         end
      end
   end
endmodule

// File: tb/tb_interrupt_controller.sv
// tb_interrupt_controller: directed checks of the interrupt controller handshake, arbitration and nesting
module tb_interrupt_controller;
   logic clk = 1'b0, rst = 1'b1;
   logic [3:0] irq = '0, int_mask = 4'hF, pending;
   logic nmi = 1'b0, intd = 1'b0, boundary = 1'b1, int_ack = 1'b0, eret = 1'b0;
   logic int_req, is_nmi, in_service;
   logic [1:0] irq_id;
   logic [31:0] vector;
   int checks = 0, errors = 0;

   interrupt_controller dut (
      .clk(clk), .rst(rst), .irq(irq), .nmi(nmi), .int_mask(int_mask), .intd(intd),
      .boundary(boundary), .int_ack(int_ack), .eret(eret), .int_req(int_req),
      .is_nmi(is_nmi), .irq_id(irq_id), .vector(vector), .in_service(in_service),
      .pending(pending)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   // Raise sources for one cycle, then wait for the request to be presented
   task automatic pulse_irq(input logic [3:0] v);
      irq = v;
      tick();
      irq = '0;
      tick();
   endtask

   task automatic ack_cycle();
      int_ack = 1'b1;
      tick();
      int_ack = 1'b0;
   endtask

   task automatic eret_cycle();
      eret = 1'b1;
      tick();
      eret = 1'b0;
   endtask

   initial begin
      #1;
      check("rst_int_req", int_req, 0);
      check("rst_in_service", in_service, 0);
      check("rst_pending", pending, 0);
      check("rst_vector", vector, 0);
      check("rst_is_nmi", is_nmi, 0);
      check("rst_irq_id", irq_id, 0);
      tick();
      rst = 1'b0;
      tick();
      // single source, boundary held high
      irq = 4'b0100;
      tick();
      irq = '0;
      check("t1_pending", pending, 4'b0100);
      check("t1_early_req", int_req, 0);
      tick();
      check("t1_int_req", int_req, 1);
      check("t1_irq_id", irq_id, 2);
      check("t1_vector", vector, 32'h90);
      check("t1_is_nmi", is_nmi, 0);
      ack_cycle();
      check("t1_pend_clr", pending, 0);
      check("t1_in_service", in_service, 1);
      check("t1_req_drop", int_req, 0);
      eret_cycle();
      check("t1_idle", in_service, 0);
      // simultaneous sources, lowest index first
      pulse_irq(4'b1010);
      check("t2_first_id", irq_id, 1);
      check("t2_first_vec", vector, 32'h88);
      ack_cycle();
      check("t2_pend_left", pending, 4'b1000);
      check("t2_no_nest", int_req, 0);
      eret_cycle();
      tick();
      check("t2_second_req", int_req, 1);
      check("t2_second_id", irq_id, 3);
      check("t2_second_vec", vector, 32'h98);
      ack_cycle();
      eret_cycle();
      // NMI preempts a maskable handler
      pulse_irq(4'b0001);
      check("t3_irq0_vec", vector, 32'h80);
      ack_cycle();
      nmi = 1'b1;
      tick();
      nmi = 1'b0;
      tick();
      check("t3_nmi_req", int_req, 1);
      check("t3_is_nmi", is_nmi, 1);
      check("t3_nmi_vec", vector, 32'h40);
      check("t3_nest_svc", in_service, 1);
      ack_cycle();
      check("t3_nmi_svc", is_nmi, 1);
      eret_cycle();
      check("t3_restore_svc", in_service, 1);
      check("t3_restore_id", irq_id, 0);
      check("t3_restore_nmi", is_nmi, 0);
      check("t3_restore_vec", vector, 32'h80);
      check("t3_restore_req", int_req, 0);
      eret_cycle();
      check("t3_idle", in_service, 0);
      // withdraw on intd, re-request at the next boundary
      pulse_irq(4'b0001);
      check("t4_req", int_req, 1);
      intd = 1'b1;
      tick();
      check("t4_withdraw", int_req, 0);
      check("t4_pend_kept", pending, 4'b0001);
      intd = 1'b0;
      boundary = 1'b0;
      tick(2);
      check("t4_no_boundary", int_req, 0);
      boundary = 1'b1;
      tick();
      check("t4_rereq", int_req, 1);
      check("t4_rereq_id", irq_id, 0);
      ack_cycle();
      eret_cycle();
      // re-rise during ack keeps the pending bit
      pulse_irq(4'b0010);
      check("t5_id", irq_id, 1);
      int_ack = 1'b1;
      irq = 4'b0010;
      tick();
      int_ack = 1'b0;
      irq = '0;
      check("t5_pend_set_wins", pending, 4'b0010);
      check("t5_in_service", in_service, 1);
      tick();
      check("t5_blocked_in_svc", int_req, 0);
      eret_cycle();
      tick();
      check("t5_second_req", int_req, 1);
      check("t5_second_id", irq_id, 1);
      // asynchronous reset mid-handshake
      #2 rst = 1'b1;
      #1;
      check("t6_async_req", int_req, 0);
      check("t6_async_pend", pending, 0);
      check("t6_async_vec", vector, 0);
      check("t6_async_svc", in_service, 0);
      irq = 4'b1000;
      tick();
      rst = 1'b0;
      int_mask = 4'b0111;
      tick();
      check("t6_held_latched", pending, 4'b1000);
      tick(2);
      check("t7_masked_noreq", int_req, 0);
      check("t7_masked_pend", pending, 4'b1000);
      int_mask = 4'hF;
      tick();
      check("t7_unmask_req", int_req, 1);
      check("t7_unmask_vec", vector, 32'h98);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
